// File: rtl/road_rage_pkg.sv
// Shared constants, state encoding and lane remap for the road-rage generators.
package road_rage_pkg;

  localparam int SCREEN_H = 120;
  localparam int CAR_H    = 30;
  localparam int PLAYER_Y = 88;

  localparam logic [1:0] LANE_0   = 2'd0;
  localparam logic [1:0] LANE_1   = 2'd1;
  localparam logic [1:0] LANE_2   = 2'd2;
  localparam logic [1:0] LANE_OFF = 2'd3;

  // state    | meaning
  // SPAWN    | pick lanes for a new wave, park it at the top row
  // RUN      | wave scrolling down, collision watched every cycle
  // HOLD     | player hit, everything frozen until reset
  typedef enum logic [1:0] {
    ST_SPAWN = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } gen_state_e;

  // Folds the two unusable patterns (no cars, all lanes blocked) onto legal masks.
  function automatic logic [2:0] remap(input logic [2:0] raw);
    logic [2:0] m;
    m = raw;
    if (raw == 3'b000) m = 3'b001;
    if (raw == 3'b111) m = 3'b110;
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right; holds when en is low.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic        fb_d;

  assign fb_d = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];
  assign q    = q_q;

  // Shift register; new bit enters at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else if (en) begin
      q_q <= {fb_d, q_q[15:1]};
    end
  end

endmodule

// File: rtl/npc_lane_generator.sv
// NPC wave generator: lane pick, vertical scroll, player collision and wave score.
module npc_lane_generator
  import road_rage_pkg::*;
#(
  parameter int          SPEED     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [1:0] player_lane,
  output logic [2:0] lane_enable,
  output logic [6:0] car_y,
  output logic       collide_yes,
  output logic       draw_reset,
  output logic [7:0] score
);

  gen_state_e  state_q;
  logic [2:0]  lane_enable_q;
  logic [6:0]  car_y_q;
  logic        collide_q;
  logic        draw_reset_q;
  logic [7:0]  score_q;

  logic [15:0] lfsr_q;
  logic [7:0]  y8_d;
  logic [7:0]  car_y_d;
  logic        lane_hit_d;
  logic        band_hit_d;
  logic        hit_d;
  logic        wave_end_d;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != ST_HOLD),
    .q     (lfsr_q)
  );

  assign y8_d       = {1'b0, car_y_q};
  assign car_y_d    = y8_d + 8'(SPEED);
  assign wave_end_d = (car_y_d >= 8'(SCREEN_H));
  assign band_hit_d = ((y8_d + 8'(CAR_H)) > 8'(PLAYER_Y)) &&
                      (y8_d < 8'(PLAYER_Y + CAR_H));
  assign hit_d      = lane_hit_d && band_hit_d;

  // Is the player's lane occupied by the current wave (off-road never is).
  always_comb begin
    lane_hit_d = 1'b0;
    case (player_lane)
      LANE_0:  lane_hit_d = lane_enable_q[0];
      LANE_1:  lane_hit_d = lane_enable_q[1];
      LANE_2:  lane_hit_d = lane_enable_q[2];
      default: lane_hit_d = 1'b0;
    endcase
  end

  // Wave sequencer with registered outputs; collision wins over a same-cycle advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SPAWN;
      lane_enable_q <= 3'b000;
      car_y_q       <= 7'd0;
      collide_q     <= 1'b0;
      draw_reset_q  <= 1'b0;
      score_q       <= 8'd0;
    end else begin
      draw_reset_q <= 1'b0;
      case (state_q)
        ST_SPAWN: begin
          lane_enable_q <= remap(lfsr_q[2:0]);
          car_y_q       <= 7'd0;
          state_q       <= ST_RUN;
        end
        ST_RUN: begin
          if (hit_d) begin
            collide_q <= 1'b1;
            state_q   <= ST_HOLD;
          end else if (advance) begin
            if (wave_end_d) begin
              draw_reset_q <= 1'b1;
              if (score_q != 8'hFF) score_q <= score_q + 8'd1;
              state_q <= ST_SPAWN;
            end else begin
              car_y_q <= car_y_d[6:0];
            end
          end
        end
        ST_HOLD: begin
          collide_q <= 1'b1;
        end
        default: begin
          state_q <= ST_SPAWN;
        end
      endcase
    end
  end

  assign lane_enable = lane_enable_q;
  assign car_y       = car_y_q;
  assign collide_yes = collide_q;
  assign draw_reset  = draw_reset_q;
  assign score       = score_q;

endmodule

// File: tb/tb_npc_lane_generator.sv
// Self-checking bench for npc_lane_generator: behavioural wave model plus directed literals.
module tb_npc_lane_generator;

  localparam int          SPEED = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int M_SPAWN = 0, M_RUN = 1, M_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       advance = 1'b0;
  logic [1:0] player_lane = 2'd3;
  logic [2:0] lane_enable;
  logic [6:0] car_y;
  logic       collide_yes;
  logic       draw_reset;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  npc_lane_generator #(.SPEED(SPEED), .LFSR_SEED(SEED)) dut (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .player_lane (player_lane),
    .lane_enable (lane_enable),
    .car_y       (car_y),
    .collide_yes (collide_yes),
    .draw_reset  (draw_reset),
    .score       (score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  function automatic int remap_m(input int raw);
    if (raw == 0) return 1;
    if (raw == 7) return 6;
    return raw;
  endfunction

  // Rows [y, y+30) of the NPC overlap rows [88, 118) of the player?
  function automatic bit rows_overlap(input int y);
    return (y + 30 > 88) && (y < 88 + 30);
  endfunction

  int          m_st, m_lanes, m_y, m_score;
  bit          m_col, m_dr;
  logic [15:0] m_lfsr;

  function automatic bit m_hit(input int lanes, input int y, input logic [1:0] pl);
    if (pl == 2'd3) return 1'b0;
    return ((lanes >> pl) & 1) == 1 && rows_overlap(y);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= M_SPAWN; m_lfsr <= SEED; m_lanes <= 0; m_y <= 0;
      m_col <= 1'b0; m_dr <= 1'b0; m_score <= 0;
    end else begin
      m_dr <= 1'b0;
      if (m_st != M_HOLD) begin
        m_lfsr <= lfsr_next(m_lfsr);
        if (m_st == M_SPAWN) begin
          m_lanes <= remap_m(int'(m_lfsr[2:0]));
          m_y     <= 0;
          m_st    <= M_RUN;
        end else if (m_hit(m_lanes, m_y, player_lane)) begin
          m_col <= 1'b1;
          m_st  <= M_HOLD;
        end else if (advance) begin
          if (m_y + SPEED >= 120) begin
            m_dr    <= 1'b1;
            m_score <= (m_score < 255) ? m_score + 1 : 255;
            m_st    <= M_SPAWN;
          end else begin
            m_y <= m_y + SPEED;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("lane_enable", int'(lane_enable), m_lanes);
      chk("car_y", int'(car_y), m_y);
      chk("collide_yes", int'(collide_yes), int'(m_col));
      chk("draw_reset", int'(draw_reset), int'(m_dr));
      chk("score", int'(score), m_score);
      if (m_st != M_SPAWN && m_lanes != 0)
        chk("lane_count_1_or_2",
            int'($countones(lane_enable) >= 1 && $countones(lane_enable) <= 2), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    advance = 1'b0;
    player_lane = 2'd3;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  int  tries;
  bit  found;
  int  e_lane;
  int  score_snap;

  initial begin
    tick(2);
    reset = 1'b0;
    cmp_en = 1'b1;

    // First spawn: seed low bits 3'b001 give lane 0 only.
    tick(1);
    chk("first_spawn_lane", int'(lane_enable), 1);
    chk("first_spawn_y", int'(car_y), 0);

    // Reset asserted between edges in mid-RUN clears outputs immediately.
    advance = 1'b1;
    tick(5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_lane", int'(lane_enable), 0);
    chk("async_rst_y", int'(car_y), 0);
    chk("async_rst_col", int'(collide_yes), 0);
    chk("async_rst_dr", int'(draw_reset), 0);
    chk("async_rst_score", int'(score), 0);
    @(negedge clk);
    advance = 1'b0;
    reset = 1'b0;
    tick(1);
    chk("post_rst_lane_legal",
        int'(lane_enable inside {3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110}), 1);
    chk("post_rst_y", int'(car_y), 0);

    // Wave boundary: 59 advances reach row 118, the 60th ends the wave.
    advance = 1'b1;
    tick(59);
    chk("y_after_59", int'(car_y), 118);
    chk("no_dr_after_59", int'(draw_reset), 0);
    tick(1);
    chk("dr_on_60th", int'(draw_reset), 1);
    chk("score_after_wave", int'(score), 1);
    chk("y_held_at_end", int'(car_y), 118);
    advance = 1'b0;
    tick(1);
    chk("dr_one_cycle", int'(draw_reset), 0);
    chk("y_respawn", int'(car_y), 0);

    // 1000 further waves off-road: lanes track the model, score saturates.
    advance = 1'b1;
    tick(1000 * 61);
    chk("score_saturated", int'(score), 255);
    advance = 1'b0;

    // Collision in lane 1, with a same-cycle advance that must be ignored.
    do_reset();
    tick(1);
    found = 1'b0;
    tries = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      if ((m_lanes & 2) != 0) found = 1'b1;
      else begin
        advance = 1'b1;
        tick(61);
        advance = 1'b0;
        tries++;
      end
    end
    chk("found_lane1_wave", int'(found), 1);
    advance = 1'b1;
    tick(29);
    chk("y_58", int'(car_y), 58);
    player_lane = 2'd1;
    tick(1);
    chk("y_60", int'(car_y), 60);
    chk("no_col_yet", int'(collide_yes), 0);
    tick(1);
    chk("col_set", int'(collide_yes), 1);
    chk("y_frozen_on_hit", int'(car_y), 60);
    chk("no_dr_on_hit", int'(draw_reset), 0);
    tick(10);
    chk("y_frozen_hold", int'(car_y), 60);
    chk("score_frozen_hold", int'(score), tries);
    chk("col_sticky", int'(collide_yes), 1);

    // Dodge into an empty lane at row 56; the wave passes without a hit.
    do_reset();
    tick(1);
    e_lane = ((m_lanes & 1) == 0) ? 0 : ((m_lanes & 2) == 0) ? 1 : 2;
    advance = 1'b1;
    tick(28);
    chk("y_56", int'(car_y), 56);
    player_lane = 2'(e_lane);
    tick(32);
    chk("dodge_dr", int'(draw_reset), 1);
    chk("dodge_no_col", int'(collide_yes), 0);
    chk("dodge_score", int'(score), 1);
    advance = 1'b0;

    // Randomised traffic: sporadic advances, wandering player, resets after crashes.
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      advance = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) player_lane = 2'($urandom_range(0, 3));
      tick(1);
      if (m_st == M_HOLD && $urandom_range(0, 7) == 0) begin
        score_snap = m_score;
        do_reset();
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
